// File: rtl/frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_arbiter
// Purpose  : Round-robin arbiter that hands a single framing encoder to one of
//            two byte-stream requesters. It streams a frame of up to MAX_LEN
//            bytes, waits for the encoder's two state-change indications
//            (end-of-receive, then end-of-transfer), enforces a quiet gap, and
//            guards the whole exchange with a watchdog.
// Ports    :
//   clk            in   clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   req[1:0]       in   per-requester frame request (level)
//   len0/len1[4:0] in   frame length in bytes, sampled at grant
//   data0/data1    in   first-word-fall-through byte per requester
//   pop[1:0]       out  one-hot byte-consumed strobe
//   grant[1:0]     out  one-hot encoder owner, held for the whole frame
//   enc_din[7:0]   out  byte to encoder
//   enc_din_valid  out  byte valid to encoder
//   enc_indicator  in   encoder state-change pulse
//   done           out  one-cycle pulse on frame completion
//   err            out  one-cycle pulse on rejected request / watchdog expiry
//   busy           out  high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module frame_arbiter #(
  parameter int MAX_LEN    = 20,
  parameter int GAP_CYCLES = 17,
  parameter int TIMEOUT    = 2047
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [4:0] len0,
  input  logic [4:0] len1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] pop,
  output logic [1:0] grant,
  output logic [7:0] enc_din,
  output logic       enc_din_valid,
  input  logic       enc_indicator,
  output logic       done,
  output logic       err,
  output logic       busy
);

  // Counter widths sized so the largest loaded/compared value always fits.
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [4:0]       MAX_LEN_C = 5'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_RX = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [WD_W-1:0]  wd_cnt, wd_nxt;
  logic             owner, owner_nxt;   // index of the granted requester
  logic             ptr, ptr_nxt;       // requester favoured at next arbitration
  logic             err_q, err_nxt;

  logic             sel;
  logic [4:0]       sel_len;
  logic [4:0]       len_clamped;
  logic             wd_expire;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      wd_cnt  <= '0;
      owner   <= 1'b0;
      ptr     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gap_cnt <= gap_nxt;
      wd_cnt  <= wd_nxt;
      owner   <= owner_nxt;
      ptr     <= ptr_nxt;
      err_q   <= err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    gap_nxt       = gap_cnt;
    wd_nxt        = wd_cnt;
    owner_nxt     = owner;
    ptr_nxt       = ptr;
    err_nxt       = 1'b0;

    // The favoured requester wins if it is asking, otherwise the other one.
    sel           = req[ptr] ? ptr : ~ptr;
    sel_len       = sel ? len1 : len0;
    len_clamped   = (sel_len > MAX_LEN_C) ? MAX_LEN_C : sel_len;
    wd_expire     = (wd_cnt == WD_LAST);

    case (state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          if (sel_len == 5'd0) begin
            // Zero-length request is refused; move on so the other side
            // is not starved by a requester stuck on a bad length.
            err_nxt = 1'b1;
            ptr_nxt = ~sel;
          end else begin
            state_nxt = ST_SEND;
            owner_nxt = sel;
            cnt_nxt   = len_clamped;
            wd_nxt    = '0;
          end
        end
      end

      ST_SEND: begin
        if (wd_expire) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
          ptr_nxt   = ~owner;
          cnt_nxt   = '0;
          wd_nxt    = '0;
        end else begin
          wd_nxt  = wd_cnt + WD_W'(1);
          cnt_nxt = cnt - 5'd1;
          if (cnt == 5'd1) begin
            state_nxt = ST_WAIT_RX;
          end
        end
      end

      ST_WAIT_RX: begin
        if (wd_expire) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
          ptr_nxt   = ~owner;
          wd_nxt    = '0;
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
          if (enc_indicator) begin
            state_nxt = ST_WAIT_TX;
          end
        end
      end

      ST_WAIT_TX: begin
        if (wd_expire) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
          ptr_nxt   = ~owner;
          wd_nxt    = '0;
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
          if (enc_indicator) begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LOAD;
            wd_nxt    = '0;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = ~owner;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Outputs decode from registered state only (plus the FWFT data path),
    // so they fall to zero as soon as reset forces IDLE.
    busy          = (state != ST_IDLE);
    grant         = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
    enc_din_valid = (state == ST_SEND);
    enc_din       = (state == ST_SEND) ? (owner ? data1 : data0) : 8'h00;
    pop           = (state == ST_SEND) ? grant : 2'b00;
    done          = (state == ST_GAP) && (gap_cnt == '0);
    err           = err_q;
  end

endmodule
`default_nettype wire

// File: doc/frame_arbiter.md
FRAME_ARBITER -- requirements
Module: frame_arbiter

Interface
REQ-001 Parameter MAX_LEN, default 20: maximum bytes per frame; equals the framing encoder queue depth in bytes.
REQ-002 Parameter GAP_CYCLES, default 17: idle cycles after end-of-transfer before the next grant, covering encoder right padding plus return to waiting.
REQ-003 Parameter TIMEOUT, default 2047: watchdog limit in cycles for the encoder to report end-of-transfer.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  2  per-requester frame request, level-sensitive.
REQ-007 len0, len1  input  5 each  frame length in bytes; sampled at grant.
REQ-008 data0, data1  input  8 each  first-word-fall-through byte from each requester.
REQ-009 pop  output  2  one-hot byte-consumed strobe; the requester advances its data on the cycle after pop.
REQ-010 grant  output  2  one-hot owner of the encoder; held for the whole frame.
REQ-011 enc_din  output  8  byte to the encoder.
REQ-012 enc_din_valid  output  1  byte valid to the encoder.
REQ-013 enc_indicator  input  1  encoder state-change pulse (end-of-receive, then end-of-transfer).
REQ-014 done  output  1  one-cycle pulse when a frame fully completes.
REQ-015 err  output  1  one-cycle pulse on a rejected request or a watchdog expiry.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 States: IDLE, SEND, WAIT_RX, WAIT_TX, GAP.
REQ-018 IDLE arbitration:
- Any req bit high selects requester i by round-robin.
- The pointer favours the requester not served last; after reset it favours requester 0.
- Next state is SEND.
- grant asserts on the same clock edge and the selected len is latched as cnt.
REQ-019 Length rules:
- len equal to 0: no grant; err pulses one cycle, the pointer advances, and the block stays in IDLE.
- len greater than MAX_LEN: clamped to MAX_LEN.
REQ-020 SEND:
- enc_din_valid equals 1 and enc_din equals data of the granted requester.
- pop bit of the granted requester equals 1.
- cnt decrements each cycle.
- Bytes go out on exactly cnt consecutive cycles with no bubbles.
- After the last byte, next state is WAIT_RX.
REQ-021 WAIT_RX:
- enc_din_valid equals 0 and enc_din equals 0.
- enc_indicator high advances the block to WAIT_TX; this is expected on the first WAIT_RX cycle.
REQ-022 WAIT_TX: enc_indicator high advances the block to GAP and loads the gap counter with GAP_CYCLES-1.
REQ-023 Watchdog:
- A watchdog counter runs from SEND entry through WAIT_RX and WAIT_TX.
- Reaching TIMEOUT forces IDLE, pulses err, drops grant, and advances the pointer.
REQ-024 GAP:
- Counts down to 0 and then enters IDLE.
- done pulses in the last GAP cycle.
- grant drops on entry to IDLE.
- No new grant is issued earlier than GAP_CYCLES cycles after the end-of-transfer indicator.
REQ-025 After a serviced frame, the pointer points to the other requester.
REQ-026 Simultaneous events:
- Both req bits high: the pointer decides.
- enc_indicator seen in SEND or GAP is ignored.
- req changes while busy are ignored; a deasserted req does not abort the frame in flight.
REQ-027 Counter widths: cnt 5 bits; gap counter and watchdog counter sized from their parameters; no wrap occurs within legal parameter values.

Reset
REQ-028 While reset_n is low, the following are 0 immediately and asynchronously: pop, grant, enc_din, enc_din_valid, done, err, busy.
REQ-029 Reset values: state IDLE, pointer favouring requester 0, all counters 0.
REQ-030 Reset asserted mid-frame abandons the frame with no done; the first grant after release is re-arbitrated from scratch.

Verification
REQ-031 req=01, len0=3, data bytes A1,A2,A3; encoder model pulses indicator at the end of receive and again at the end of transfer -> enc_din_valid high 3 consecutive cycles carrying A1,A2,A3; pop=01 on those same 3 cycles; done 1 pulse; grant 01 throughout.
REQ-032 req=11 continuously, len0=len1=2 -> grants alternate 01,10,01; consecutive grants are separated by at least 17 cycles after each end-of-transfer indicator.
REQ-033 req=10, len1=0 -> err 1 pulse, no grant, no pop, busy stays 0.
REQ-034 req=01, len0=25 -> exactly 20 bytes sent, 20 pops.
REQ-035 Encoder model never issues the second indicator -> err pulses TIMEOUT cycles after SEND entry, grant drops, and the next req=10 is granted.
REQ-036 reset_n pulsed low during SEND -> all outputs 0 immediately, no done, busy 0; req=11 after release grants 01.
